// File: rtl/pinwheel_ram_pkg.sv
// Shared types and helpers for the pinwheel data/instruction RAM ports.
// byte_merge overlays the enabled lanes of a new word onto an old word.
package pinwheel_ram_pkg;

  localparam int word_bits  = 32;
  localparam int lane_count = 4;

  typedef enum logic {
    ACCEPT = 1'b0,
    MERGE  = 1'b1
  } state_t;

  function automatic logic [word_bits-1:0] byte_merge(
    input logic [word_bits-1:0]  old_word,
    input logic [word_bits-1:0]  new_word,
    input logic [lane_count-1:0] mask
  );
    logic [word_bits-1:0] merged;
    merged = old_word;
    for (int i = 0; i < lane_count; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/pinwheel_ram_port.sv
// Byte-addressed load/store front end for the word-wide pinwheel data RAM.
// Partial stores become a two-cycle read-modify-write because the RAM has no byte enables.
module pinwheel_ram_port
  import pinwheel_ram_pkg::*;
#(
  parameter  int size_bytes     = 512,
  localparam int addr_bits      = $clog2(size_bytes / 4),
  localparam int byte_addr_bits = addr_bits + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [byte_addr_bits-1:0] req_addr,
  input  logic [lane_count-1:0]     req_wmask,
  input  logic [word_bits-1:0]      req_wdata,
  output logic                      rsp_valid,
  output logic [word_bits-1:0]      rsp_data,
  output logic [addr_bits-1:0]      ram_raddr,
  input  logic [word_bits-1:0]      ram_rdata,
  output logic [addr_bits-1:0]      ram_waddr,
  output logic [word_bits-1:0]      ram_wdata,
  output logic                      ram_wren
);

  localparam logic [lane_count-1:0] full_mask = '1;

  state_t                 state_reg;
  logic                   rd_pend;
  logic [addr_bits-1:0]   addr_reg;
  logic [lane_count-1:0]  mask_reg;
  logic [word_bits-1:0]   wdata_reg;

  logic                   accept;
  logic                   partial;
  logic [addr_bits-1:0]   req_word;
  logic [1:0]             unused_lsbs;

  assign req_word    = req_addr[byte_addr_bits-1:2];
  assign unused_lsbs = req_addr[1:0];

  // Ready is forced low while rst is held so nothing is accepted during reset.
  assign req_ready = (state_reg == ACCEPT) && !rst;
  assign accept    = req_valid && req_ready;
  assign partial   = (req_wmask != full_mask) && (req_wmask != '0);

  assign rsp_valid = rd_pend;
  assign rsp_data  = ram_rdata;

  always_comb begin
    ram_raddr = req_word;
    ram_waddr = req_word;
    ram_wdata = req_wdata;
    ram_wren  = 1'b0;
    if (state_reg == MERGE) begin
      // ram_rdata now holds the old word fetched on the accepting edge.
      ram_raddr = addr_reg;
      ram_waddr = addr_reg;
      ram_wdata = byte_merge(ram_rdata, wdata_reg, mask_reg);
      ram_wren  = 1'b1;
    end else if (accept && req_write && (req_wmask == full_mask)) begin
      ram_wren  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCEPT;
      rd_pend   <= 1'b0;
      addr_reg  <= '0;
      mask_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      rd_pend <= accept && !req_write;
      case (state_reg)
        ACCEPT: begin
          if (accept && req_write && partial) begin
            addr_reg  <= req_word;
            mask_reg  <= req_wmask;
            wdata_reg <= req_wdata;
            state_reg <= MERGE;
          end
        end
        MERGE:   state_reg <= ACCEPT;
        default: state_reg <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_pinwheel_ram_port.sv
// Bench for pinwheel_ram_port: behavioural RAM beside the DUT, byte-array model
// and a queue of expected load data popped whenever a response appears.
module tb_pinwheel_ram_port;

  localparam int size_bytes = 512;
  localparam int addr_bits  = 7;
  localparam int byte_bits  = 9;
  localparam int word_count = size_bytes / 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic                 req_write = 1'b0;
  logic [byte_bits-1:0] req_addr = '0;
  logic [3:0]           req_wmask = '0;
  logic [31:0]          req_wdata = '0;
  logic                 rsp_valid;
  logic [31:0]          rsp_data;
  logic [addr_bits-1:0] ram_raddr;
  logic [31:0]          ram_rdata;
  logic [addr_bits-1:0] ram_waddr;
  logic [31:0]          ram_wdata;
  logic                 ram_wren;

  logic [31:0] mem [0:word_count-1];
  logic [7:0]  model [0:size_bytes-1];
  logic [31:0] exp_q [$];
  int n_vec = 0;
  int n_miss = 0;
  int wren_count = 0;

  pinwheel_ram_port #(.size_bytes(size_bytes)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wren(ram_wren)
  );

  always #5 clk = ~clk;

  // Word-wide RAM with registered read, as attached in the real system.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [byte_bits-1:0] a);
    int b;
    b = int'(a[byte_bits-1:2]) * 4;
    return {model[b+3], model[b+2], model[b+1], model[b]};
  endfunction

  always @(negedge clk) begin
    if (ram_wren) wren_count++;
    if (rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_spurious", 32'd1, 32'd0);
      else check("rsp_data", rsp_data, exp_q.pop_front());
    end
  end

  // Called just after a rising edge; returns just after the edge where the
  // request (and any merge cycle) has completed.
  task automatic issue(input logic w, input logic [byte_bits-1:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    int waited;
    int b;
    waited = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wmask = m; req_wdata = d;
    @(negedge clk);
    while (!req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    check("raddr", 32'(ram_raddr), 32'(a[byte_bits-1:2]));
    if (w) begin
      if (m == 4'hF) begin
        check("full_wren", 32'(ram_wren), 32'd1);
        check("full_waddr", 32'(ram_waddr), 32'(a[byte_bits-1:2]));
        check("full_wdata", ram_wdata, d);
      end else begin
        check("accept_wren", 32'(ram_wren), 32'd0);
      end
      b = int'(a[byte_bits-1:2]) * 4;
      for (int i = 0; i < 4; i++) if (m[i]) model[b+i] = d[8*i +: 8];
    end else begin
      exp_q.push_back(model_word(a));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (w && m != 4'hF && m != 4'h0) begin
      check("merge_ready", 32'(req_ready), 32'd0);
      check("merge_wren", 32'(ram_wren), 32'd1);
      check("merge_waddr", 32'(ram_waddr), 32'(a[byte_bits-1:2]));
      check("merge_wdata", ram_wdata, model_word(a));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    logic [3:0] m;
    // Reset state
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("post_rst_ready", 32'(req_ready), 32'd1);

    // Initialise every word with a full store so the model tracks the whole RAM.
    for (int i = 0; i < word_count; i++) issue(1'b1, byte_bits'(i * 4), 4'hF, $urandom);
    issue(1'b1, 9'h010, 4'hF, 32'hDEADBEEF);
    issue(1'b1, 9'h030, 4'hF, 32'hAABBCCDD);
    issue(1'b1, 9'h040, 4'hF, 32'h11223344);
    issue(1'b1, 9'h050, 4'hF, 32'hCAFEF00D);
    @(posedge clk); #1;

    // Load after preload
    issue(1'b0, 9'h010, 4'h0, 32'h0);
    check("ld_rsp_valid", 32'(rsp_valid), 32'd1);
    check("ld_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Full store then immediate load; one write strobe only
    w0 = wren_count;
    issue(1'b1, 9'h020, 4'hF, 32'h12345678);
    issue(1'b0, 9'h020, 4'h0, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("full_wren_cycles", 32'(wren_count - w0), 32'd1);

    // Partial store then load at N+2
    issue(1'b1, 9'h030, 4'b0010, 32'h00001100);
    check("merge_model", model_word(9'h030), 32'hAABB11DD);
    issue(1'b0, 9'h030, 4'h0, 32'h0);
    @(posedge clk); #1;

    // Mask-zero store is dropped
    w0 = wren_count;
    issue(1'b1, 9'h040, 4'h0, 32'hFFFFFFFF);
    check("mask0_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 9'h040, 4'h0, 32'h0);
    @(posedge clk); #1;
    check("mask0_wren", 32'(wren_count - w0), 32'd0);

    // Reset pulsed during MERGE abandons the write
    w0 = wren_count;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h050; req_wmask = 4'b0100; req_wdata = 32'h00990000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstm_ready", 32'(req_ready), 32'd0);
    check("rstm_wren_before", 32'(ram_wren), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstm_wren", 32'(ram_wren), 32'd0);
    check("rstm_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstm_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstm_ready_after", 32'(req_ready), 32'd1);
    check("rstm_word", mem[20], 32'hCAFEF00D);
    check("rstm_wren_count", 32'(wren_count - w0), 32'd0);
    @(posedge clk); #1;

    // Random mix against the byte-array model
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      case ($urandom_range(0, 5))
        0:       m = 4'hF;
        1:       m = 4'h0;
        default: m = 4'($urandom_range(0, 15));
      endcase
      issue(1'($urandom_range(0, 1)), byte_bits'($urandom_range(0, size_bytes - 1)), m, $urandom);
    end

    repeat (3) @(posedge clk); #1;
    check("rsp_outstanding", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < word_count; i++) check("final_word", mem[i], model_word(byte_bits'(i * 4)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
